// File: rtl/tl_timed_cntr.sv
// -----------------------------------------------------------------------------
// tl_timed_cntr
//
// Timed sequencer for a two-road intersection. A Moore FSM steps through the
// four phases A green -> A yellow -> B green -> B yellow. The road sensors and
// a per-state dwell timer decide when each phase ends:
//   - a green phase lasts at least MIN_GREEN cycles;
//   - a green phase ends after MAX_GREEN cycles if the other road is waiting;
//   - a yellow phase lasts exactly YELLOW cycles, whatever the sensors do.
//
// Parameters
//   MIN_GREEN : minimum green dwell in cycles          (1 <= MIN_GREEN)
//   MAX_GREEN : forced-exit green dwell in cycles      (MIN_GREEN <= MAX_GREEN <= 2^TW-1)
//   YELLOW    : exact yellow dwell in cycles           (1 <= YELLOW <= 2^TW)
//   TW        : dwell timer width
//
// Ports
//   clk      in   1   rising-edge clock
//   reset_n  in   1   asynchronous active-low reset
//   Ta       in   1   traffic present on road A
//   Tb       in   1   traffic present on road B
//   cs       out  2   current state: S0=00 S1=01 S2=10 S3=11 (registered)
//   La       out  2   road A light: green=00 yellow=01 red=10 (decoded from cs)
//   Lb       out  2   road B light: same encoding as La
//   tmr      out  TW  cycles spent in the current state, from 0, saturating
// -----------------------------------------------------------------------------
module tl_timed_cntr #(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 16,
    parameter int YELLOW    = 3,
    parameter int TW        = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          Ta,
    input  logic          Tb,
    output logic [1:0]    cs,
    output logic [1:0]    La,
    output logic [1:0]    Lb,
    output logic [TW-1:0] tmr
);

    // Phase encoding is visible on cs, so the values are fixed.
    typedef enum logic [1:0] {
        S0_A_GREEN  = 2'b00,
        S1_A_YELLOW = 2'b01,
        S2_B_GREEN  = 2'b10,
        S3_B_YELLOW = 2'b11
    } state_t;

    localparam logic [1:0] LIGHT_GREEN  = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_RED    = 2'b10;

    // The timer holds the number of cycles already spent in the state, so a
    // dwell of N cycles ends on the edge that samples tmr = N-1.
    localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_LAST = TW'(YELLOW - 1);
    localparam logic [TW-1:0] TMR_SAT  = {TW{1'b1}};

    state_t        r_state;
    state_t        w_next_state;
    logic [TW-1:0] r_tmr;
    logic [TW-1:0] w_tmr_next;
    logic          w_min_done;
    logic          w_max_done;
    logic          w_yel_done;
    logic          w_state_change;

    // -------------------------------------------------------------------------
    // Dwell qualifiers shared by both roads' green and yellow phases.
    // -------------------------------------------------------------------------
    assign w_min_done = (r_tmr >= MIN_LAST);
    assign w_max_done = (r_tmr >= MAX_LAST);
    assign w_yel_done = (r_tmr == YEL_LAST);

    // -------------------------------------------------------------------------
    // Next-state logic. A green phase ends early when its own road empties
    // (after the minimum), or is forced to end when the other road has waited
    // for the maximum. Both terms are ORed, so they can never conflict.
    // Yellow ignores the sensors completely.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assigned first so every path drives the signal and no latch is inferred.
        w_next_state = r_state;
        unique case (r_state)
            S0_A_GREEN: begin
                if ((w_min_done && !Ta) || (w_max_done && Tb))
                    w_next_state = S1_A_YELLOW;
            end
            S1_A_YELLOW: begin
                if (w_yel_done)
                    w_next_state = S2_B_GREEN;
            end
            S2_B_GREEN: begin
                if ((w_min_done && !Tb) || (w_max_done && Ta))
                    w_next_state = S3_B_YELLOW;
            end
            S3_B_YELLOW: begin
                if (w_yel_done)
                    w_next_state = S0_A_GREEN;
            end
            default: w_next_state = S0_A_GREEN;
        endcase
    end

    // -------------------------------------------------------------------------
    // Dwell timer: restarts at 0 on entry to a new state and otherwise counts
    // up, sticking at all-ones so a long starvation hold never wraps back into
    // the short-dwell range.
    // -------------------------------------------------------------------------
    assign w_state_change = (w_next_state != r_state);

    always_comb begin
        w_tmr_next = r_tmr;
        if (w_state_change)
            w_tmr_next = '0;
        else if (r_tmr != TMR_SAT)
            w_tmr_next = r_tmr + TW'(1);
    end

    // -------------------------------------------------------------------------
    // State and timer registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S0_A_GREEN;
            r_tmr   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            r_state <= w_next_state;
            r_tmr   <= w_tmr_next;
        end
    end

    // -------------------------------------------------------------------------
    // Moore output decode from the registered state only; lights change in the
    // same cycle as cs. The 2'b11 light code is never produced.
    // -------------------------------------------------------------------------
    always_comb begin
        La = LIGHT_RED;
        Lb = LIGHT_RED;
        unique case (r_state)
            S0_A_GREEN:  begin La = LIGHT_GREEN;  Lb = LIGHT_RED;    end
            S1_A_YELLOW: begin La = LIGHT_YELLOW; Lb = LIGHT_RED;    end
            S2_B_GREEN:  begin La = LIGHT_RED;    Lb = LIGHT_GREEN;  end
            S3_B_YELLOW: begin La = LIGHT_RED;    Lb = LIGHT_YELLOW; end
            default:     begin La = LIGHT_RED;    Lb = LIGHT_RED;    end
        endcase
    end

    assign cs  = r_state;
    assign tmr = r_tmr;

endmodule

// File: tb/tb_tl_timed_cntr.sv
// -----------------------------------------------------------------------------
// tb_tl_timed_cntr
//
// Directed bench for tl_timed_cntr with default parameters. Every clocked step
// drives the sensors, advances a small behavioural model of the controller and
// pushes the expected {cs, La, Lb, tmr} onto a scoreboard queue; one time unit
// after the edge the DUT outputs are popped against it. Scenario-specific
// points (phase lengths, saturation, period) are also checked as constants.
// -----------------------------------------------------------------------------
module tb_tl_timed_cntr;

    localparam int MIN_GREEN = 4;
    localparam int MAX_GREEN = 16;
    localparam int YELLOW    = 3;
    localparam int TW        = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          Ta;
    logic          Tb;
    logic [1:0]    cs;
    logic [1:0]    La;
    logic [1:0]    Lb;
    logic [TW-1:0] tmr;

    always #5 clk = ~clk;

    tl_timed_cntr #(
        .MIN_GREEN (MIN_GREEN),
        .MAX_GREEN (MAX_GREEN),
        .YELLOW    (YELLOW),
        .TW        (TW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .Ta      (Ta),
        .Tb      (Tb),
        .cs      (cs),
        .La      (La),
        .Lb      (Lb),
        .tmr     (tmr)
    );

    typedef struct packed {
        logic [1:0]    cs;
        logic [1:0]    la;
        logic [1:0]    lb;
        logic [TW-1:0] tmr;
    } obs_t;

    obs_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   m_cs  = 0;
    int   m_tmr = 0;

    // Light tables from the phase description.
    function automatic logic [1:0] exp_la(input int s);
        logic [1:0] tab [4] = '{2'b00, 2'b01, 2'b10, 2'b10};
        return tab[s];
    endfunction

    function automatic logic [1:0] exp_lb(input int s);
        logic [1:0] tab [4] = '{2'b10, 2'b10, 2'b00, 2'b01};
        return tab[s];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural model: one clock edge with the given sensor values.
    task automatic model_step(input logic ta, input logic tb);
        bit go;
        go = 1'b0;
        case (m_cs)
            0: go = (m_tmr >= MIN_GREEN - 1 && !ta) || (m_tmr >= MAX_GREEN - 1 && tb);
            1: go = (m_tmr == YELLOW - 1);
            2: go = (m_tmr >= MIN_GREEN - 1 && !tb) || (m_tmr >= MAX_GREEN - 1 && ta);
            3: go = (m_tmr == YELLOW - 1);
            default: go = 1'b0;
        endcase
        if (go) begin
            m_cs  = (m_cs + 1) % 4;
            m_tmr = 0;
        end else if (m_tmr < (2 ** TW) - 1) begin
            m_tmr++;
        end
    endtask

    task automatic push_exp();
        obs_t e;
        e.cs  = 2'(m_cs);
        e.la  = exp_la(m_cs);
        e.lb  = exp_lb(m_cs);
        e.tmr = TW'(m_tmr);
        sb_q.push_back(e);
    endtask

    task automatic check_sb(input string tag);
        obs_t e;
        obs_t o;
        o.cs  = cs;
        o.la  = La;
        o.lb  = Lb;
        o.tmr = tmr;
        tests++;
        if (sb_q.size() == 0) begin
            fails++;
            $error("FAIL %s: scoreboard empty, observed cs=%b tmr=%0d", tag, cs, tmr);
        end else begin
            e = sb_q.pop_front();
            assert (o === e) else begin
                fails++;
                $error("FAIL %s: observed cs=%b La=%b Lb=%b tmr=%0d expected cs=%b La=%b Lb=%b tmr=%0d",
                       tag, o.cs, o.la, o.lb, o.tmr, e.cs, e.la, e.lb, e.tmr);
            end
        end
    endtask

    // Called 1 unit after a rising edge: drive sensors, predict, clock, compare.
    task automatic step(input logic ta, input logic tb, input string tag);
        Ta = ta;
        Tb = tb;
        model_step(ta, tb);
        push_exp();
        @(posedge clk);
        #1;
        check_sb(tag);
    endtask

    // Async reset pulse between edges; outputs must be at reset values before
    // any clock edge, then the cycle-0 state is compared after release.
    task automatic pulse_reset(input string tag);
        reset_n = 1'b0;
        #1;
        chk({tag, "_cs"},  32'(cs),  32'd0);
        chk({tag, "_tmr"}, 32'(tmr), 32'd0);
        chk({tag, "_La"},  32'(La),  32'b00);
        chk({tag, "_Lb"},  32'(Lb),  32'b10);
        #1;
        reset_n = 1'b1;
        m_cs  = 0;
        m_tmr = 0;
        push_exp();
        check_sb({tag, "_cycle0"});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] cs_log [77];
        int         both_green;
        int         period_err;
        int         not_s0;
        bit         found;

        reset_n = 1'b1;
        Ta      = 1'b1;
        Tb      = 1'b1;

        // ---- Reset state (asserted before the first clock edge) ----
        #1 reset_n = 1'b0;
        #1;
        chk("reset_cs",  32'(cs),  32'd0);
        chk("reset_tmr", 32'(tmr), 32'd0);
        chk("reset_La",  32'(La),  32'b00);
        chk("reset_Lb",  32'(Lb),  32'b10);
        @(posedge clk);
        #1;
        chk("reset_held_cs", 32'(cs), 32'd0);
        reset_n = 1'b1;
        m_cs  = 0;
        m_tmr = 0;
        push_exp();
        check_sb("release_cycle0");

        // ---- Minimum green: Ta=0, Tb=1 -> 00 x4, 01 x3, 10 ----
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 1'b1, "min_green");
            if (i == 3) chk("min_green_c3_cs", 32'(cs), 32'd0);
            if (i == 4) chk("min_green_c4_cs", 32'(cs), 32'd1);
            if (i == 6) chk("min_green_c6_cs", 32'(cs), 32'd1);
            if (i == 7) begin
                chk("min_green_c7_cs", 32'(cs), 32'd2);
                chk("min_green_c7_Lb", 32'(Lb), 32'b00);
            end
        end

        // ---- Late sensor drop: Ta held until tmr=9 ----
        pulse_reset("rst_late");
        for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, "late_hold");
        chk("late_hold_tmr", 32'(tmr), 32'd9);
        chk("late_hold_cs",  32'(cs),  32'd0);
        step(1'b0, 1'b0, "late_drop");
        chk("late_drop_cs",  32'(cs),  32'd1);
        chk("late_drop_tmr", 32'(tmr), 32'd0);
        step(1'b0, 1'b0, "late_yel");
        step(1'b0, 1'b0, "late_yel");
        chk("late_yel_end_cs", 32'(cs), 32'd1);
        step(1'b0, 1'b0, "late_s2");
        chk("late_s2_cs",  32'(cs),  32'd2);
        chk("late_s2_tmr", 32'(tmr), 32'd0);

        // ---- Yellow immunity, then empty-road minimum-period alternation ----
        pulse_reset("rst_yel");
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, "empty_s0");
        chk("yel_entry_cs", 32'(cs), 32'd1);
        step(1'b1, 1'b1, "yel_toggle");
        chk("yel_t1_cs", 32'(cs), 32'd1);
        step(1'b0, 1'b0, "yel_toggle");
        chk("yel_t2_cs", 32'(cs), 32'd1);
        step(1'b1, 1'b0, "yel_toggle");
        chk("yel_exit_cs", 32'(cs), 32'd2);
        for (int i = 1; i <= 14; i++) step(1'b0, 1'b0, "empty_cycle");
        chk("empty_cycle_cs",  32'(cs),  32'd2);
        chk("empty_cycle_tmr", 32'(tmr), 32'd0);

        // ---- Maximum green fairness: both roads busy, period 38 ----
        pulse_reset("rst_fair");
        both_green = 0;
        period_err = 0;
        cs_log[0]  = cs;
        for (int i = 1; i <= 76; i++) begin
            step(1'b1, 1'b1, "fair");
            cs_log[i] = cs;
            if (La == 2'b00 && Lb == 2'b00) both_green++;
        end
        for (int i = 0; i < 38; i++)
            if (cs_log[i] !== cs_log[i + 38]) period_err++;
        chk("fair_c15_cs", 32'(cs_log[15]), 32'd0);
        chk("fair_c16_cs", 32'(cs_log[16]), 32'd1);
        chk("fair_c19_cs", 32'(cs_log[19]), 32'd2);
        chk("fair_c34_cs", 32'(cs_log[34]), 32'd2);
        chk("fair_c35_cs", 32'(cs_log[35]), 32'd3);
        chk("fair_c38_cs", 32'(cs_log[38]), 32'd0);
        chk("fair_period", 32'(period_err), 32'd0);
        chk("fair_both_green", 32'(both_green), 32'd0);

        // ---- Reset mid-operation at cs=10, tmr=7 ----
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(1'b1, 1'b1, "mid_run");
            if (cs == 2'b10 && tmr == TW'(7)) found = 1'b1;
        end
        chk("mid_found", 32'(found), 32'd1);
        pulse_reset("rst_mid");
        not_s0 = 0;
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b1, "mid_after");
            if (i <= 15 && cs != 2'b00) not_s0++;
        end
        chk("mid_s0_hold", 32'(not_s0), 32'd0);
        chk("mid_exit_cs", 32'(cs), 32'd1);

        // ---- Starvation hold and timer saturation ----
        pulse_reset("rst_starve");
        not_s0 = 0;
        for (int i = 1; i <= 50; i++) begin
            step(1'b1, 1'b0, "starve");
            if (cs != 2'b00) not_s0++;
            if (i == 30) chk("starve_c30_tmr", 32'(tmr), 32'd30);
            if (i == 31) chk("starve_c31_tmr", 32'(tmr), 32'd31);
        end
        chk("starve_cs_hold", 32'(not_s0), 32'd0);
        chk("starve_c50_tmr", 32'(tmr), 32'd31);
        step(1'b1, 1'b1, "starve_release");
        chk("starve_exit_cs",  32'(cs),  32'd1);
        chk("starve_exit_tmr", 32'(tmr), 32'd0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tl_timed_cntr.md
# tl_timed_cntr

Timed two-road traffic light controller. It sequences the four-state phase cycle (A green, A yellow, B green, B yellow) from the road sensors `Ta` and `Tb`. It enforces a minimum green time, a maximum green time when the other road is waiting, and a fixed yellow time. It replaces the untimed state register / next-state / output-decode chain as the top-level sequencer for the intersection.

## Interface
Parameters:
- `MIN_GREEN`, 4: minimum cycles a green phase (S0/S2) is held.
- `MAX_GREEN`, 16: green cycles after which the phase is forced to end if the other road is waiting.
- `YELLOW`, 3: exact cycles a yellow phase (S1/S3) is held.
- `TW`, 5: timer width.
- Legal range: 1 ≤ `YELLOW`; 1 ≤ `MIN_GREEN` ≤ `MAX_GREEN` ≤ 2^TW−1.

Ports:
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `Ta` input 1: traffic present on road A (1 = cars waiting or flowing).
- `Tb` input 1: traffic present on road B.
- `cs` output 2: current state; S0=00, S1=01, S2=10, S3=11.
- `La` output 2: road A light; green=00, yellow=01, red=10.
- `Lb` output 2: road B light; same encoding as `La`.
- `tmr` output TW: cycles spent in the current state, counted from 0.

## Operation
- Moore FSM:
  - `cs` is registered.
  - `La` and `Lb` are decoded combinationally from `cs` only.
  - S0: La=00, Lb=10. S1: La=01, Lb=10. S2: La=10, Lb=00. S3: La=10, Lb=01.
- `tmr` is a registered dwell counter:
  - On any state change it loads 0.
  - Otherwise it increments by 1 each cycle.
  - It saturates at 2^TW−1 and never wraps.
- Transitions use `Ta`, `Tb` and `tmr` as sampled at the rising edge:
  - S0→S1 when (`tmr` ≥ MIN_GREEN−1 and `Ta`=0) or (`tmr` ≥ MAX_GREEN−1 and `Tb`=1). Otherwise S0 holds.
  - S1→S2 when `tmr` = YELLOW−1. Otherwise S1 holds.
  - S2→S3 when (`tmr` ≥ MIN_GREEN−1 and `Tb`=0) or (`tmr` ≥ MAX_GREEN−1 and `Ta`=1). Otherwise S2 holds.
  - S3→S0 when `tmr` = YELLOW−1. Otherwise S3 holds.
- Both roads empty (`Ta`=`Tb`=0): the green phase still ends after MIN_GREEN cycles, and the lights keep alternating at minimum period.
- Own road busy and other road empty: the green phase holds indefinitely. `tmr` saturates at 31 (with TW=5) and stays there.
- Both terms of an exit condition true in the same cycle: a single transition occurs; there is no priority conflict.
- A sensor change during a yellow phase has no effect on that phase; yellow length is fixed.
- Encoding 2'b11 on `La`/`Lb` is never driven.

## Timing
- Reset (`reset_n`=0): takes effect immediately, without waiting for a clock edge.
  - `cs`=00, `tmr`=0, `La`=00, `Lb`=10.
  - Reset asserted in mid-phase (any state, any `tmr`) returns to S0 with `tmr`=0.
- First cycle after reset release: S0 with `tmr`=0. The first edge with `reset_n`=1 increments `tmr` to 1.
- Dwell times:
  - Green: at least MIN_GREEN cycles.
  - Green with the other road waiting: at most MAX_GREEN cycles.
  - Yellow: exactly YELLOW cycles.
- Sensor-to-state latency: a sensor change seen at edge k, with the timer condition met, changes `cs` at edge k. Lights change in the same cycle that `cs` changes; there is no extra register stage.
- Sensor glitches: a one-cycle `Ta`=0 pulse at `tmr` ≥ MIN_GREEN−1 is sufficient to leave S0. No filtering is applied.

## Test plan
- Reset mid-operation:
  - Stimulus: run with `Ta`=`Tb`=1 until `cs`=10 and `tmr`=7, then pulse `reset_n`=0 between clock edges.
  - Required: `cs`=00, `tmr`=0, `La`=00, `Lb`=10 before the next edge; after release, S0 holds for 16 cycles.
- Minimum green:
  - Stimulus: defaults, `Ta`=0, `Tb`=1 from reset release.
  - Required: `cs` sequence 00×4, 01×3, 10…; `Lb`=00 from cycle 7.
- Late sensor drop:
  - Stimulus: `Ta`=1, `Tb`=0; drop `Ta` to 0 at `tmr`=9.
  - Required: S0→S1 on that edge; S1 lasts 3 cycles; S2 entered with `tmr`=0.
- Maximum green fairness:
  - Stimulus: `Ta`=`Tb`=1 constant.
  - Required: repeating period of 38 cycles (S0 16, S1 3, S2 16, S3 3); `La`/`Lb` never both 00.
- Starvation hold and saturation:
  - Stimulus: `Ta`=1, `Tb`=0 for 50 cycles.
  - Required: `cs`=00 throughout; `tmr` reaches 31 at cycle 31 and stays 31.
  - Then raise `Tb`=1: S1 entered on the next edge.
- Yellow immunity:
  - Stimulus: in S1, toggle `Ta`/`Tb` every cycle.
  - Required: S1 lasts exactly 3 cycles, then `cs`=10.
